// File: rtl/bank_read_sched.sv
// rtl/bank_read_sched.sv - bank-conflict-free read pass scheduler; optional broadcast merge via BANK_READ_SCHED_BCAST_EN
module bank_read_sched #(
    parameter int NBANK = 16,
    parameter int NDATA = 32,
    parameter int ID_BW = 2,
    localparam int BW   = $clog2(NBANK),
    localparam int ABW  = $clog2(NDATA) + BW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 addrin_rdy,
    output logic                 addrin_ack,
    input  logic [NBANK*ABW-1:0] i_raddr,
    input  logic [NBANK-1:0]     i_lane_en,
    input  logic [ID_BW-1:0]     i_id,
    input  logic                 i_retire,
    output logic                 dout_rdy,
    input  logic                 dout_ack,
    output logic [NBANK*ABW-1:0] o_raddr,
    output logic [NBANK-1:0]     o_lane_en,
    output logic [ID_BW-1:0]     o_id,
    output logic                 o_retire,
    output logic                 o_busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NBANK*ABW-1:0] addr_q;
    logic [NBANK-1:0]     pend_q;
    logic [ID_BW-1:0]     id_q;
    logic                 retire_q;
    logic [NBANK-1:0]     sel;
    logic                 last;
    logic                 busy;
    logic                 xfer;
    logic                 accept;

    assign busy   = (state_q == ISSUE);
    assign last   = (sel == pend_q);
    assign xfer   = busy & dout_ack;
    assign accept = addrin_rdy & (~busy | (dout_ack & last));

    // Pick the lanes for this pass: a pending lane is blocked by any lower
    // pending lane on the same bank (unless broadcast merge allows an
    // identical address to share the bank access).
    always_comb begin : sel_p
        logic blocked;
        sel     = '0;
        blocked = 1'b0;
        for (int j = 0; j < NBANK; j++) begin
            blocked = 1'b0;
            for (int k = 0; k < j; k++) begin
                if (pend_q[k] && (addr_q[k*ABW +: BW] == addr_q[j*ABW +: BW])) begin
`ifdef BANK_READ_SCHED_BCAST_EN
                    if (addr_q[k*ABW +: ABW] != addr_q[j*ABW +: ABW])
                        blocked = 1'b1;
`else
                    blocked = 1'b1;
`endif
                end
            end
            sel[j] = pend_q[j] & ~blocked;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: stay in ISSUE until the last pass leaves with no follow-on request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (xfer && last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture on acceptance; retire served lanes on each transfer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr_q   <= '0;
            pend_q   <= '0;
            id_q     <= '0;
            retire_q <= 1'b0;
        end else if (accept) begin
            addr_q   <= i_raddr;
            pend_q   <= i_lane_en;
            id_q     <= i_id;
            retire_q <= i_retire;
        end else if (xfer) begin
            pend_q   <= pend_q & ~sel;
        end
    end

    // Output pass view: addresses of unselected lanes are forced to zero.
    always_comb begin
        o_raddr = '0;
        for (int j = 0; j < NBANK; j++) begin
            if (busy && sel[j])
                o_raddr[j*ABW +: ABW] = addr_q[j*ABW +: ABW];
        end
    end

    assign addrin_ack = accept;
    assign dout_rdy   = busy;
    assign o_busy     = busy;
    assign o_lane_en  = busy ? sel : '0;
    assign o_id       = id_q;
    assign o_retire   = busy & retire_q & last;

endmodule

// File: doc/bank_read_sched.md
BANK_READ_SCHED -- requirements
Module: bank_read_sched

Interface
REQ-001 SHALL have parameter NBANK, default 16, giving the lane and bank count (power of two, 2..64).
REQ-002 SHALL have parameter NDATA, default 32, giving the words per bank; ABW = clog2(NDATA)+clog2(NBANK).
REQ-003 SHALL have parameter ID_BW, default 2, giving the request ID width.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port addrin_rdy, input, 1 bit: a request is offered.
REQ-007 SHALL have port addrin_ack, output, 1 bit: the request is accepted this cycle.
REQ-008 SHALL have port i_raddr, input, ABW x NBANK: per-lane address, bank = low clog2(NBANK) bits.
REQ-009 SHALL have port i_lane_en, input, NBANK bits: lanes participating in the request.
REQ-010 SHALL have port i_id, input, ID_BW bits: request ID.
REQ-011 SHALL have port i_retire, input, 1 bit: free the ID after the final pass.
REQ-012 SHALL have port dout_rdy, output, 1 bit: a conflict-free pass is presented.
REQ-013 SHALL have port dout_ack, input, 1 bit: the pass is consumed.
REQ-014 SHALL have port o_raddr, output, ABW x NBANK: per-lane pass address; 0 on unselected lanes.
REQ-015 SHALL have port o_lane_en, output, NBANK bits: lanes served in this pass.
REQ-016 SHALL have port o_id, output, ID_BW bits: ID of the current request.
REQ-017 SHALL have port o_retire, output, 1 bit: latched i_retire AND this is the last pass.
REQ-018 SHALL have port o_busy, output, 1 bit: high while in state ISSUE.

Function
REQ-019 SHALL implement two states: IDLE and ISSUE.
REQ-020 SHALL drive addrin_ack = addrin_rdy AND (IDLE OR (dout_ack AND current pass is last)).
REQ-021 On acceptance, SHALL latch i_raddr, i_lane_en (as the pending mask), i_id and i_retire, and enter or stay in ISSUE.
REQ-022 SHALL assert dout_rdy only in ISSUE, starting the cycle after acceptance (1-cycle latency).
REQ-023 dout_ack SHALL be asserted only while dout_rdy=1; a transfer occurs on a cycle where dout_ack=1.
REQ-024 SHALL select pending lane j iff no pending lane k<j has the same bank (lowest lane wins).
REQ-025 SHALL hold o_raddr, o_lane_en, o_id and o_retire stable while dout_rdy=1 and dout_ack=0.
REQ-026 On transfer, SHALL clear the selected lanes from the pending mask.
REQ-027 The last pass SHALL be the pass whose selected mask equals the pending mask.
REQ-028 SHALL go to IDLE after transferring the last pass unless a new request is accepted in the same cycle.
REQ-029 Passes per request SHALL equal the maximum number of enabled lanes mapping to any one bank.
REQ-030 A request with i_lane_en=0 SHALL produce exactly one pass with o_lane_en=0 and o_retire=i_retire, so the ID is still freed.
REQ-031 Every cycle's selection SHALL be conflict-free: at most one distinct address per bank.

Reset
REQ-032 While i_rst=0: state=IDLE, pending mask=0, latched addresses=0, id=0, retire=0.
REQ-033 While i_rst=0: addrin_ack=0, dout_rdy=0, o_busy=0, o_retire=0, o_lane_en=0, o_raddr all 0, o_id=0.
REQ-034 Reset asserted mid-request SHALL discard the request with no further passes emitted.

Configuration
REQ-035 SHALL use macro BANK_READ_SCHED_BCAST_EN.
REQ-036 When BANK_READ_SCHED_BCAST_EN is defined, a lane j SHALL also be selected when every lower pending lane with the same bank has an identical full address (broadcast merge).
REQ-037 When BANK_READ_SCHED_BCAST_EN is undefined, REQ-024 SHALL apply strictly and identical addresses SHALL be served in separate passes.

Verification
REQ-038 Bench SHALL cover: 16 lanes, lane i addr i, mask FFFF, retire=1 -> one pass, o_lane_en=FFFF, o_retire=1, dout_rdy 1 cycle after ack.
REQ-039 Bench SHALL cover: 16 lanes, addr 16*i (all bank 0), mask FFFF -> 16 passes with o_lane_en=1<<k for pass k; o_retire=1 only on pass 15.
REQ-040 Bench SHALL cover: all lanes addr 0x25 -> 1 pass of FFFF with BCAST_EN; 16 passes without.
REQ-041 Bench SHALL cover: mask 0, id=2, retire=1 -> single pass, o_lane_en=0, o_id=2, o_retire=1.
REQ-042 Bench SHALL cover: dout_ack held 0 for 5 cycles mid-request -> outputs constant; new request offered during the last-pass ack -> accepted the same cycle, no idle bubble.
REQ-043 Bench SHALL cover: i_rst low during pass 3 of 16 -> all outputs 0 next sample; after release, a fresh request starts at pass 0.
